// File: rtl/template_core.sv
// Single-cycle registered N-bit two-operand ALU with result, valid, zero and illegal-op flags.
// Optional multiply (op 10) is built only when TEMPLATE_MUL_EN is defined.
module template_core #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [3:0]   op,
  input  logic [N-1:0] inputX,
  input  logic [N-1:0] inputY,
  output logic [N-1:0] outputZ,
  output logic         out_valid,
  output logic         zero,
  output logic         illegal
);

  localparam int SW = $clog2(N);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
`ifdef TEMPLATE_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  logic [N-1:0]  result_q, result_d;
  logic          valid_q;
  logic          zero_q, zero_d;
  logic          illegal_q, illegal_d;
  logic [SW-1:0] shamt;
  logic          unused_shamt_hi;

  // Only the low log2(N) bits select the shift distance; the rest are don't-care.
  assign shamt           = inputY[SW-1:0];
  assign unused_shamt_hi = ^inputY[N-1:SW];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    result_d  = '0;
    illegal_d = 1'b0;
    unique case (op)
      OP_ADD:  result_d = inputX + inputY;
      OP_SUB:  result_d = inputX - inputY;
      OP_AND:  result_d = inputX & inputY;
      OP_OR:   result_d = inputX | inputY;
      OP_XOR:  result_d = inputX ^ inputY;
      OP_SLL:  result_d = inputX << shamt;
      OP_SRL:  result_d = inputX >> shamt;
      OP_SRA:  result_d = $signed(inputX) >>> shamt;
      OP_SLT:  result_d = {{(N-1){1'b0}}, ($signed(inputX) < $signed(inputY))};
      OP_SLTU: result_d = {{(N-1){1'b0}}, (inputX < inputY)};
`ifdef TEMPLATE_MUL_EN
      OP_MUL:  result_d = inputX * inputY;
`endif
      default: illegal_d = 1'b1;
    endcase
    zero_d = (result_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q  <= result_d;
        zero_q    <= zero_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign outputZ   = result_q;
  assign out_valid = valid_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_template_core.sv
// Self-checking bench for template_core: directed corner cases plus randomized ops
// compared every cycle against an arithmetic reference model.
module tb_template_core;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [N-1:0] inputX = '0;
  logic [N-1:0] inputY = '0;
  logic [N-1:0] outputZ;
  logic         out_valid;
  logic         zero;
  logic         illegal;

  int checks   = 0;
  int failures = 0;

  // Expected registered outputs, advanced once per issued cycle.
  logic [N-1:0] exp_z     = '0;
  logic         exp_valid = 1'b0;
  logic         exp_zero  = 1'b1;
  logic         exp_ill   = 1'b0;

  template_core #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .op       (op),
    .inputX   (inputX),
    .inputY   (inputY),
    .outputZ  (outputZ),
    .out_valid(out_valid),
    .zero     (zero),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference computed from the operation rules with plain integer arithmetic.
  task automatic ref_alu(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                         output logic [N-1:0] z, output logic ill);
    longint ux, uy, sx, sy, p, q, r;
    logic [63:0] wide;
    int s;
    ux  = longint'(x);
    uy  = longint'(y);
    sx  = x[N-1] ? ux - (longint'(1) << N) : ux;
    sy  = y[N-1] ? uy - (longint'(1) << N) : uy;
    s   = int'(y % N);
    p   = longint'(1) << s;
    ill = 1'b0;
    r   = 0;
    case (o)
      4'd0: r = ux + uy;
      4'd1: r = ux - uy + (longint'(1) << N);
      4'd2: r = ux & uy;
      4'd3: r = ux | uy;
      4'd4: r = ux ^ uy;
      4'd5: r = ux * p;
      4'd6: r = ux / p;
      4'd7: begin
        if (sx >= 0) q = sx / p;
        else         q = -((-sx + p - 1) / p);
        r = q;
      end
      4'd8: r = (sx < sy) ? 1 : 0;
      4'd9: r = (ux < uy) ? 1 : 0;
`ifdef TEMPLATE_MUL_EN
      4'd10: begin
        wide = {32'd0, x} * {32'd0, y};
        r = longint'(wide[N-1:0]);
      end
`endif
      default: begin
        r   = 0;
        ill = 1'b1;
      end
    endcase
    wide = r;
    z    = wide[N-1:0];
  endtask

  // Compare the previous cycle's outcome, then drive this cycle and advance the model.
  task automatic step(input logic v, input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] z;
    logic         ill;
    @(negedge clk);
    check("z", outputZ, exp_z);
    check("out_valid", N'(out_valid), N'(exp_valid));
    check("zero", N'(zero), N'(exp_zero));
    check("illegal", N'(illegal), N'(exp_ill));
    in_valid = v;
    op       = o;
    inputX   = x;
    inputY   = y;
    exp_valid = v;
    if (v) begin
      ref_alu(o, x, y, z, ill);
      exp_z    = z;
      exp_zero = (z == '0);
      exp_ill  = ill;
    end
  endtask

  // Issue one op and check the spec-given literal result right after the capturing edge.
  task automatic directed(input string tag, input logic [3:0] o, input logic [N-1:0] x,
                          input logic [N-1:0] y, input logic [N-1:0] z, input logic zf,
                          input logic il);
    step(1'b1, o, x, y);
    @(posedge clk);
    #1;
    check({tag, "_z"}, outputZ, z);
    check({tag, "_zero"}, N'(zero), N'(zf));
    check({tag, "_ill"}, N'(illegal), N'(il));
    check({tag, "_valid"}, N'(out_valid), N'(1'b1));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_z"}, outputZ, '0);
    check({tag, "_valid"}, N'(out_valid), '0);
    check({tag, "_zero"}, N'(zero), N'(1'b1));
    check({tag, "_ill"}, N'(illegal), '0);
  endtask

  function automatic logic [N-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    logic [N-1:0] held_z;

    // Reset held for three cycles, driven inputs must not matter.
    in_valid = 1'b1;
    op       = 4'd4;
    inputX   = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      check_reset_state("rst_hold");
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_reset_state("rst_release");

    // Arithmetic wrap.
    directed("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    directed("sub_wrap", 4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Shifts and compares.
    directed("sra",  4'd7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0);
    directed("srl",  4'd6, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0);
    directed("sll0", 4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    directed("slt",  4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    directed("sltu", 4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);

    // Illegal op and optional multiply.
    directed("op15", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b1);
`ifdef TEMPLATE_MUL_EN
    directed("mul", 4'd10, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0, 1'b0);
`else
    directed("mul_off", 4'd10, 32'h0001_0000, 32'h0001_0001, 32'h0000_0000, 1'b1, 1'b1);
`endif

    // Back-to-back ADD stream, then one idle cycle with unknown operands.
    for (int i = 0; i < 100; i++) step(1'b1, 4'd0, rand_operand(), rand_operand());
    step(1'b0, 4'd0, 'x, 'x);
    held_z = exp_z;
    @(posedge clk);
    #1;
    check("idle_valid", N'(out_valid), '0);
    check("idle_hold", outputZ, held_z);

    // Randomized mixed traffic with sporadic idle cycles.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
    step(1'b1, 4'd3, 32'h00F0_0000, 32'h0000_000F);

    // Asynchronous reset between edges clears outputs immediately.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    in_valid  = 1'b0;
    exp_z     = '0;
    exp_valid = 1'b0;
    exp_zero  = 1'b1;
    exp_ill   = 1'b0;
    @(negedge clk);
    check_reset_state("async_rst_hold");

    // First op after release is taken on the first rising edge with rst_n high.
    rst_n = 1'b1;
    in_valid = 1'b1;
    op       = 4'd0;
    inputX   = 32'd40;
    inputY   = 32'd2;
    @(posedge clk);
    #1;
    check("post_rst_z", outputZ, 32'd42);
    check("post_rst_valid", N'(out_valid), N'(1'b1));
    exp_z     = 32'd42;
    exp_valid = 1'b1;
    exp_zero  = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 4'($urandom_range(0, 9)), rand_operand(), rand_operand());
    step(1'b0, 4'd0, '0, '0);
    step(1'b0, 4'd0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/template_core.md
# template_core

Single-cycle registered 32-bit two-operand arithmetic/logic unit, used as the reference pattern for PhilosophyV datapath blocks. It accepts operands `inputX` and `inputY` plus an operation code under a valid strobe. One clock later it presents the result on `outputZ`, along with a valid flag and a zero flag. It sits between operand fetch and writeback in the datapath.

## Interface
- `N`, default 32: operand and result width. Must be at least 8. Shift amounts use the low `$clog2(N)` bits of `inputY`.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low. Asserting it clears all registers immediately; release is synchronised externally.
- `in_valid`, input, 1: the operands and opcode on this cycle are to be executed.
- `op`, input, 4: operation select (encodings listed under Operation).
- `inputX`, input, N: operand A.
- `inputY`, input, N: operand B, or the shift amount for shift operations.
- `outputZ`, output, N: registered result.
- `out_valid`, output, 1: `outputZ` holds a fresh result this cycle.
- `zero`, output, 1: registered; high when the `outputZ` value being loaded is 0.
- `illegal`, output, 1: registered; high when a captured `op` is undefined.

## Operation
- 0 ADD: X+Y, modulo 2^N.
- 1 SUB: X−Y, modulo 2^N.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 SLL: X << Y[log2N−1:0].
- 6 SRL: logical right shift by the same amount.
- 7 SRA: arithmetic right shift by the same amount.
- 8 SLT: 1 if signed X < signed Y, else 0, zero-extended to N bits.
- 9 SLTU: the same comparison, unsigned.
- 10 MUL: low N bits of X*Y. Present only with `TEMPLATE_MUL_EN`.
- Any other code is illegal: `outputZ`=0, `zero`=1, `illegal`=1.
- When `in_valid`=0: `outputZ`, `zero` and `illegal` hold their previous values, and `out_valid`=0.
- Upper shift-amount bits of `Y` are ignored. A shift of 0 returns X unchanged.
- No overflow or carry flag; wrap-around is silent.

## Timing
- Latency is exactly 1 cycle. Operands sampled on rising edge k appear on `outputZ` after edge k and are stable until the next captured operation.
- Throughput is one operation per cycle. There is no backpressure; a new operation may be issued every cycle.
- `out_valid` is high in the cycle after each `in_valid` cycle, and low otherwise.
- Reset values: `outputZ`=0, `out_valid`=0, `zero`=1, `illegal`=0.
- If `rst_n` asserts mid-operation, the pending result is discarded. The first operation after release is accepted on the first rising edge with `rst_n`=1.
- `X`/`Z` on inputs while `in_valid`=0 must not disturb the outputs.

## Configuration
- `TEMPLATE_MUL_EN` defined: op 10 computes the low N bits of the unsigned product, with the same 1-cycle latency. The multiplier is a single-cycle array that synthesis may infer as DSP.
- `TEMPLATE_MUL_EN` undefined: op 10 is illegal (`outputZ`=0, `zero`=1, `illegal`=1), and no multiplier logic is built.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release. Required: `outputZ`=0, `out_valid`=0, `zero`=1, `illegal`=0 throughout and after. Then assert `rst_n` asynchronously between edges and confirm the outputs clear immediately.
- Arithmetic wrap:
  - ADD 0xFFFFFFFF + 0x00000001 → `outputZ`=0, `zero`=1 on the next cycle.
  - SUB 0 − 1 → 0xFFFFFFFF, `zero`=0.
- Shifts and compares:
  - SRA 0x80000000 by `Y`=0x00000024 (effective shift 4) → 0xF8000000.
  - SRL of the same operands → 0x08000000.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLTU of the same operands → 0.
- Back-to-back streaming: 100 vectors with `in_valid`=1 every cycle from the team's standard 96-bit X|Y|expected vector file (op=ADD). Each result matches one cycle later with `out_valid` continuously high. Then drop `in_valid` for 1 cycle: `out_valid`=0 and `outputZ` held.
- Illegal/MUL:
  - op 15 → `outputZ`=0, `illegal`=1.
  - op 10 with 0x00010000 × 0x00010001 → 0x00010000 when `TEMPLATE_MUL_EN` is defined; `illegal`=1 when it is not.
